// File: rtl/wb_initiator_seq_if.sv
// Command/response and Wishbone initiator signal bundle for wb_initiator_seq.
// The master modport is the initiator's view; the slave modport is its environment.
interface wb_initiator_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_initiator_seq.sv
// Single-beat Wishbone classic initiator: one command in, one bus cycle, one response out.
// A watchdog aborts cycles whose responder never acks (e.g. an inactive user project).
module wb_initiator_seq #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  wb_initiator_seq_if.master bus,
  output logic [15:0]        err_count
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q;
  logic            cyc_q, stb_q, we_q;
  logic [3:0]      sel_q;
  logic [31:0]     adr_q, wdat_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [31:0]     rsp_dat_q;
  logic [TO_W-1:0] wd_q;
  logic [15:0]     err_cnt_q;
  logic            ack;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // An inactive responder may leave ack floating; only a clean 1 counts.
  assign ack = (bus.wbm_ack_i == 1'b1);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      wd_q        <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= bus.cmd_we;
            sel_q   <= bus.cmd_sel;
            adr_q   <= bus.cmd_adr;
            wdat_q  <= bus.cmd_we ? bus.cmd_dat : 32'd0;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (ack) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            rsp_dat_q   <= we_q ? 32'd0 : bus.wbm_dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            wd_q <= wd_q + TO_W'(1);
            // Abort on the TIMEOUT-th stb cycle so stb is high exactly TIMEOUT cycles.
            if (wd_q == WD_LAST) begin
              cyc_q       <= 1'b0;
              stb_q       <= 1'b0;
              we_q        <= 1'b0;
              sel_q       <= '0;
              adr_q       <= '0;
              wdat_q      <= '0;
              rsp_dat_q   <= ERR_DATA;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              err_cnt_q   <= sat_inc16(err_cnt_q);
              state_q     <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            wd_q        <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = wdat_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_wb_initiator_seq.sv
// Directed bench for wb_initiator_seq with a negedge Wishbone responder model.
module tb_wb_initiator_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic        resp_en    = 1'b0;
  int          resp_waits = 0;
  logic [31:0] resp_rdata = 32'd0;
  logic        ack_force  = 1'b0;
  int          stb_cycles = 0;
  int          stb_pulses = 0;
  int          wcnt       = 0;
  logic        stb_prev   = 1'b0;

  wb_initiator_seq_if bus_if();

  wb_initiator_seq #(
    .TIMEOUT (8),
    .TO_W    (8),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus_if),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Responder: acks after resp_waits stb cycles when enabled, otherwise stays silent.
  always @(negedge clk) begin
    if (bus_if.wbm_stb_o) begin
      stb_cycles++;
      if (!stb_prev) stb_pulses++;
      if (resp_en && wcnt == resp_waits) begin
        bus_if.wbm_ack_i = 1'b1;
        bus_if.wbm_dat_i = resp_rdata;
      end else begin
        bus_if.wbm_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      bus_if.wbm_ack_i = ack_force;
      wcnt = 0;
    end
    stb_prev = bus_if.wbm_stb_o;
  end

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    check("cmd_ready_before_cmd", bus_if.cmd_ready, 1);
    stb_cycles = 0;
    stb_pulses = 0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = we;
    bus_if.cmd_adr   = adr;
    bus_if.cmd_dat   = dat;
    bus_if.cmd_sel   = sel;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_adr   = 32'hFFFF_FFFF;
    bus_if.cmd_dat   = 32'hFFFF_FFFF;
    bus_if.cmd_sel   = 4'h0;
    check("stb_after_accept", bus_if.wbm_stb_o, 1);
    check("cyc_after_accept", bus_if.wbm_cyc_o, 1);
    check("cmd_ready_busy", bus_if.cmd_ready, 0);
  endtask

  task automatic wait_rsp(input int max_cycles);
    int n = 0;
    while (!bus_if.rsp_valid && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_valid_within_bound", bus_if.rsp_valid, 1);
  endtask

  task automatic consume_rsp();
    bus_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b0;
    check("rsp_valid_after_consume", bus_if.rsp_valid, 0);
    check("cmd_ready_after_consume", bus_if.cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_adr   = 32'd0;
    bus_if.cmd_dat   = 32'd0;
    bus_if.cmd_sel   = 4'h0;
    bus_if.rsp_ready = 1'b0;
    bus_if.wbm_ack_i = 1'b0;
    bus_if.wbm_dat_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus_if.cmd_ready, 1);
    check("rst_cyc", bus_if.wbm_cyc_o, 0);
    check("rst_stb", bus_if.wbm_stb_o, 0);
    check("rst_rsp_valid", bus_if.rsp_valid, 0);
    check("rst_rsp_dat", bus_if.rsp_dat, 0);
    check("rst_adr", bus_if.wbm_adr_o, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write, zero-wait ack: one-cycle stb, response on the following edge
    resp_en = 1'b1; resp_waits = 0; resp_rdata = 32'h5555_AAAA;
    send_cmd(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF);
    check("wr_we", bus_if.wbm_we_o, 1);
    check("wr_adr", bus_if.wbm_adr_o, 32'h3000_0000);
    check("wr_dat", bus_if.wbm_dat_o, 32'h1234_5678);
    check("wr_sel", bus_if.wbm_sel_o, 4'hF);
    check("wr_rsp_not_yet", bus_if.rsp_valid, 0);
    @(posedge clk); #1;
    check("wr_rsp_valid", bus_if.rsp_valid, 1);
    check("wr_stb_dropped", bus_if.wbm_stb_o, 0);
    check("wr_cyc_dropped", bus_if.wbm_cyc_o, 0);
    check("wr_adr_cleared", bus_if.wbm_adr_o, 0);
    check("wr_rsp_err", bus_if.rsp_err, 0);
    check("wr_rsp_dat", bus_if.rsp_dat, 0);
    check("wr_stb_cycles", stb_cycles, 1);
    check("wr_stb_pulses", stb_pulses, 1);
    consume_rsp();

    // Read with three wait states
    resp_waits = 3; resp_rdata = 32'hCAFE_F00D;
    send_cmd(1'b0, 32'h3000_0004, 32'h1111_2222, 4'hF);
    check("rd_we", bus_if.wbm_we_o, 0);
    check("rd_dat_o_zero", bus_if.wbm_dat_o, 0);
    check("rd_adr", bus_if.wbm_adr_o, 32'h3000_0004);
    wait_rsp(20);
    check("rd_stb_cycles", stb_cycles, 4);
    check("rd_rsp_dat", bus_if.rsp_dat, 32'hCAFE_F00D);
    check("rd_rsp_err", bus_if.rsp_err, 0);
    check("rd_err_count", err_count, 0);
    consume_rsp();

    // Responder never acks: watchdog abort after exactly TIMEOUT stb cycles
    resp_en = 1'b0;
    send_cmd(1'b0, 32'h3000_0008, 32'd0, 4'hF);
    wait_rsp(20);
    check("to_stb_cycles", stb_cycles, 8);
    check("to_stb_pulses", stb_pulses, 1);
    check("to_rsp_err", bus_if.rsp_err, 1);
    check("to_rsp_dat", bus_if.rsp_dat, 32'hDEAD_BEEF);
    check("to_err_count", err_count, 1);
    check("to_cyc_dropped", bus_if.wbm_cyc_o, 0);
    consume_rsp();

    // Ack lands on the last watchdog cycle: ack wins
    resp_en = 1'b1; resp_waits = 7; resp_rdata = 32'h0000_1357;
    send_cmd(1'b0, 32'h3000_000C, 32'd0, 4'hF);
    wait_rsp(20);
    check("last_stb_cycles", stb_cycles, 8);
    check("last_rsp_err", bus_if.rsp_err, 0);
    check("last_rsp_dat", bus_if.rsp_dat, 32'h0000_1357);
    check("last_err_count", err_count, 1);
    consume_rsp();

    // Response back-pressure: held stable, new commands ignored
    resp_waits = 1; resp_rdata = 32'hA5A5_5A5A;
    send_cmd(1'b0, 32'h3000_0010, 32'd0, 4'h1);
    wait_rsp(20);
    bus_if.cmd_valid = 1'b1; bus_if.cmd_we = 1'b1;
    bus_if.cmd_adr = 32'h3000_0020; bus_if.cmd_dat = 32'h7777_8888; bus_if.cmd_sel = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_rsp_valid", bus_if.rsp_valid, 1);
      check("stall_rsp_dat", bus_if.rsp_dat, 32'hA5A5_5A5A);
      check("stall_rsp_err", bus_if.rsp_err, 0);
      check("stall_cmd_ready", bus_if.cmd_ready, 0);
      check("stall_no_stb", bus_if.wbm_stb_o, 0);
    end
    bus_if.cmd_valid = 1'b0;
    check("stall_stb_pulses", stb_pulses, 1);
    consume_rsp();
    resp_waits = 0;
    send_cmd(1'b1, 32'h3000_0020, 32'h7777_8888, 4'h3);
    check("post_stall_sel", bus_if.wbm_sel_o, 4'h3);
    check("post_stall_dat", bus_if.wbm_dat_o, 32'h7777_8888);
    wait_rsp(5);
    consume_rsp();

    // Stray ack while idle must be ignored
    ack_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ack_cmd_ready", bus_if.cmd_ready, 1);
    check("idle_ack_rsp_valid", bus_if.rsp_valid, 0);
    check("idle_ack_cyc", bus_if.wbm_cyc_o, 0);
    ack_force = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a bus cycle
    resp_en = 1'b0;
    send_cmd(1'b0, 32'h3000_0030, 32'd0, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    check("mid_stb_high", bus_if.wbm_stb_o, 1);
    rst_n = 1'b0;
    #1;
    check("arst_stb", bus_if.wbm_stb_o, 0);
    check("arst_cyc", bus_if.wbm_cyc_o, 0);
    check("arst_err_count", err_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", bus_if.cmd_ready, 1);
    check("post_rst_rsp_valid", bus_if.rsp_valid, 0);
    check("post_rst_stb", bus_if.wbm_stb_o, 0);
    resp_en = 1'b1; resp_waits = 0; resp_rdata = 32'h0F0F_F0F0;
    send_cmd(1'b0, 32'h3000_0040, 32'd0, 4'hF);
    wait_rsp(5);
    check("post_rst_rd_dat", bus_if.rsp_dat, 32'h0F0F_F0F0);
    consume_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
